// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_arbiter_if : D-cache / I-cache / SDRAM-controller bus bundle
// Revision 1.0
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              DStrobe;
    logic              DMRW;
    logic [ADDR_W-1:0] DMAddress;
    logic              DGrant;
    logic              DSDR_TxD;
    logic              DSDR_RxD;

    logic              IStrobe;
    logic [ADDR_W-1:0] IMAddress;
    logic              IGrant;
    logic              ISDR_RxD;

    logic              SdrReq;
    logic              SdrWrite;
    logic [ADDR_W-1:0] SdrAddr;
    logic              SdrAck;
    logic              SdrRdValid;
    logic              SdrWrNext;

    logic              Busy;

    // Arbiter side
    modport slave (
        input  DStrobe, DMRW, DMAddress, IStrobe, IMAddress,
        input  SdrAck, SdrRdValid, SdrWrNext,
        output DGrant, DSDR_TxD, DSDR_RxD, IGrant, ISDR_RxD,
        output SdrReq, SdrWrite, SdrAddr, Busy
    );

    // Caches plus SDRAM controller side
    modport master (
        output DStrobe, DMRW, DMAddress, IStrobe, IMAddress,
        output SdrAck, SdrRdValid, SdrWrNext,
        input  DGrant, DSDR_TxD, DSDR_RxD, IGrant, ISDR_RxD,
        input  SdrReq, SdrWrite, SdrAddr, Busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_arbiter : round-robin D/I cache arbiter for burst SDRAM transfers
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32
) (
    input  logic            Clk_i,
    input  logic            Reset_i,
    mem_bus_arbiter_if.slave bus
);

    localparam int C_LOW_W = $clog2(BURST_LEN);
    localparam int C_CNT_W = C_LOW_W + 1;
    localparam logic [C_CNT_W-1:0] C_LAST_BEAT  = C_CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]  C_ALIGN_MASK = ~(ADDR_W'(BURST_LEN - 1));

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMD     = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic                own_d_q,  own_d_d;   // 1: D-cache owns the bus
    logic                rd_q,     rd_d;
    logic                wr_q,     wr_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [C_CNT_W-1:0]  cnt_q,    cnt_d;
    logic                last_i_q, last_i_d;  // 1: I-cache was last owner

    logic                w_pick_d;
    logic                w_beat;
    logic                w_owner_strobe;
    logic                w_xfer;
    logic                w_active;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q  <= S_IDLE;
            own_d_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            last_i_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            last_i_q <= last_i_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        own_d_d        = own_d_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        last_i_d       = last_i_q;
        // Contention goes to D unless D held the bus last
        w_pick_d       = bus.DStrobe && (!bus.IStrobe || last_i_q);
        w_beat         = rd_q ? bus.SdrRdValid : bus.SdrWrNext;
        w_owner_strobe = own_d_q ? bus.DStrobe : bus.IStrobe;

        unique case (state_q)
            S_IDLE: begin
                if (bus.DStrobe || bus.IStrobe) begin
                    own_d_d = w_pick_d;
                    rd_d    = w_pick_d ? bus.DMRW : 1'b1;
                    wr_d    = w_pick_d & ~bus.DMRW;
                    addr_d  = (w_pick_d ? bus.DMAddress : bus.IMAddress) & C_ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.SdrAck) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (w_beat) begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                    if (cnt_q == C_LAST_BEAT) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                last_i_d = ~own_d_q;
                // Wait for the owner to retire its strobe so it is not re-granted
                if (!w_owner_strobe) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_xfer   = (state_q == S_XFER);
    assign w_active = (state_q == S_CMD) || w_xfer;

    assign bus.DGrant   = w_active & own_d_q;
    assign bus.IGrant   = w_active & ~own_d_q;
    assign bus.SdrReq   = (state_q == S_CMD);
    assign bus.SdrWrite = wr_q;
    assign bus.SdrAddr  = addr_q;
    assign bus.Busy     = (state_q != S_IDLE);

    assign bus.DSDR_RxD = w_xfer & own_d_q & rd_q & bus.SdrRdValid;
    assign bus.DSDR_TxD = w_xfer & own_d_q & ~rd_q & bus.SdrWrNext;
    assign bus.ISDR_RxD = w_xfer & ~own_d_q & bus.SdrRdValid;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter : directed self-checking bench for mem_bus_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_bus_arbiter_if #(.ADDR_W(32)) bus ();

    mem_bus_arbiter #(
        .BURST_LEN (4),
        .ADDR_W    (32)
    ) u_dut (
        .Clk_i   (clk),
        .Reset_i (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] wpat;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.DStrobe = 0; bus.DMRW = 0; bus.DMAddress = '0;
        bus.IStrobe = 0; bus.IMAddress = '0;
        bus.SdrAck = 0; bus.SdrRdValid = 0; bus.SdrWrNext = 0;

        // Reset values
        #2;
        chk("rst_dgrant",  32'(bus.DGrant),   32'd0);
        chk("rst_igrant",  32'(bus.IGrant),   32'd0);
        chk("rst_sdrreq",  32'(bus.SdrReq),   32'd0);
        chk("rst_sdrwr",   32'(bus.SdrWrite), 32'd0);
        chk("rst_busy",    32'(bus.Busy),     32'd0);
        chk("rst_sdraddr", bus.SdrAddr,       32'd0);

        // D read burst from 0x106
        @(posedge clk); #1;
        rst = 1'b0;
        bus.DStrobe = 1; bus.DMRW = 1; bus.DMAddress = 32'h0000_0106;
        step();
        chk("rd_dgrant",  32'(bus.DGrant),   32'd1);
        chk("rd_igrant",  32'(bus.IGrant),   32'd0);
        chk("rd_sdrreq",  32'(bus.SdrReq),   32'd1);
        chk("rd_sdraddr", bus.SdrAddr,       32'h0000_0104);
        chk("rd_sdrwr",   32'(bus.SdrWrite), 32'd0);
        chk("rd_busy",    32'(bus.Busy),     32'd1);
        bus.SdrRdValid = 1; #1;
        chk("stray_cmd_rxd", 32'(bus.DSDR_RxD), 32'd0);
        bus.SdrRdValid = 0; bus.SdrAck = 1;
        step();
        bus.SdrAck = 0;
        chk("rd_xfer_sdrreq", 32'(bus.SdrReq), 32'd0);
        chk("rd_xfer_dgrant", 32'(bus.DGrant), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.SdrRdValid = 1; bus.SdrWrNext = 1; #1;
            chk("rd_beat_rxd",  32'(bus.DSDR_RxD), 32'd1);
            chk("rd_beat_txd",  32'(bus.DSDR_TxD), 32'd0);
            chk("rd_beat_irxd", 32'(bus.ISDR_RxD), 32'd0);
            chk("rd_beat_addr", bus.SdrAddr,       32'h0000_0104);
            step();
        end
        bus.SdrWrNext = 0;
        // Fifth beat arrives in RELEASE
        chk("rd_rel_dgrant", 32'(bus.DGrant),   32'd0);
        chk("rd_5th_rxd",    32'(bus.DSDR_RxD), 32'd0);
        step();
        bus.SdrRdValid = 0;
        // Owner keeps strobe high: stay in RELEASE, no new command
        for (int i = 0; i < 2; i++) begin
            chk("held_dgrant", 32'(bus.DGrant), 32'd0);
            chk("held_sdrreq", 32'(bus.SdrReq), 32'd0);
            chk("held_busy",   32'(bus.Busy),   32'd1);
            step();
        end
        bus.DStrobe = 0;
        step();
        chk("rd_idle_busy", 32'(bus.Busy), 32'd0);

        // D write burst with gapped SdrWrNext
        bus.DStrobe = 1; bus.DMRW = 0; bus.DMAddress = 32'h0000_0200;
        step();
        chk("wr_dgrant",  32'(bus.DGrant),   32'd1);
        chk("wr_sdrwr",   32'(bus.SdrWrite), 32'd1);
        chk("wr_sdraddr", bus.SdrAddr,       32'h0000_0200);
        bus.DStrobe = 0;
        bus.SdrAck = 1;
        step();
        bus.SdrAck = 0;
        wpat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            bus.SdrWrNext = wpat[5-i]; bus.SdrRdValid = 1; #1;
            chk("wr_txd",      32'(bus.DSDR_TxD), 32'(wpat[5-i]));
            chk("wr_rxd",      32'(bus.DSDR_RxD), 32'd0);
            chk("wr_irxd",     32'(bus.ISDR_RxD), 32'd0);
            step();
        end
        bus.SdrWrNext = 0; bus.SdrRdValid = 0;
        chk("wr_rel_dgrant", 32'(bus.DGrant), 32'd0);
        chk("wr_rel_busy",   32'(bus.Busy),   32'd1);
        step();
        chk("wr_idle_busy", 32'(bus.Busy), 32'd0);

        // I read, reset after two beats, then a fresh full burst
        bus.IStrobe = 1; bus.IMAddress = 32'h0000_0037;
        step();
        chk("i_igrant",  32'(bus.IGrant),   32'd1);
        chk("i_dgrant",  32'(bus.DGrant),   32'd0);
        chk("i_sdraddr", bus.SdrAddr,       32'h0000_0034);
        chk("i_sdrwr",   32'(bus.SdrWrite), 32'd0);
        bus.SdrAck = 1;
        step();
        bus.SdrAck = 0;
        for (int i = 0; i < 2; i++) begin
            bus.SdrRdValid = 1; #1;
            chk("i_pre_rxd", 32'(bus.ISDR_RxD), 32'd1);
            step();
        end
        rst = 1'b1; #1;
        chk("mid_rst_igrant", 32'(bus.IGrant),   32'd0);
        chk("mid_rst_busy",   32'(bus.Busy),     32'd0);
        chk("mid_rst_rxd",    32'(bus.ISDR_RxD), 32'd0);
        chk("mid_rst_addr",   bus.SdrAddr,       32'd0);
        chk("mid_rst_req",    32'(bus.SdrReq),   32'd0);
        #1;
        rst = 1'b0; bus.SdrRdValid = 0;
        step();
        chk("i2_igrant", 32'(bus.IGrant), 32'd1);
        chk("i2_sdrreq", 32'(bus.SdrReq), 32'd1);
        bus.SdrAck = 1;
        step();
        bus.SdrAck = 0;
        for (int i = 0; i < 4; i++) begin
            bus.SdrRdValid = 1; #1;
            chk("i2_rxd",    32'(bus.ISDR_RxD), 32'd1);
            chk("i2_igrant", 32'(bus.IGrant),   32'd1);
            step();
        end
        bus.SdrRdValid = 0;
        chk("i2_rel_igrant", 32'(bus.IGrant), 32'd0);
        bus.IStrobe = 0;
        step();
        chk("i2_idle_busy", 32'(bus.Busy), 32'd0);

        // Contention from reset: expect D, I, D, I
        rst = 1'b1; #1;
        rst = 1'b0;
        bus.DStrobe = 1; bus.DMRW = 1; bus.DMAddress = 32'h0000_0040;
        bus.IStrobe = 1; bus.IMAddress = 32'h0000_0080;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            step();
            chk("ct_dgrant", 32'(bus.DGrant), 32'(exp_d));
            chk("ct_igrant", 32'(bus.IGrant), 32'(!exp_d));
            chk("ct_addr",   bus.SdrAddr,     exp_d ? 32'h0000_0040 : 32'h0000_0080);
            bus.SdrAck = 1;
            step();
            bus.SdrAck = 0;
            for (int i = 0; i < 4; i++) begin
                bus.SdrRdValid = 1; #1;
                chk("ct_both", 32'(bus.DGrant & bus.IGrant), 32'd0);
                chk("ct_rxd",  32'(exp_d ? bus.DSDR_RxD : bus.ISDR_RxD), 32'd1);
                step();
            end
            bus.SdrRdValid = 0; #1;
            chk("ct_rel_d", 32'(bus.DGrant), 32'd0);
            chk("ct_rel_i", 32'(bus.IGrant), 32'd0);
            if (exp_d) bus.DStrobe = 0; else bus.IStrobe = 0;
            step();
            chk("ct_idle_busy", 32'(bus.Busy), 32'd0);
            bus.DStrobe = 1; bus.IStrobe = 1;
        end
        bus.DStrobe = 0; bus.IStrobe = 0;
        step();
        chk("end_busy", 32'(bus.Busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4, halfword beats per cache-line transfer (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 32, memory halfword-address width.
REQ-003 Single clock and reset: reset is asynchronous and active-high.
REQ-004 Clk  in  1  rising-edge clock for all state.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 DStrobe  in  1  D-cache memory request (its MStrobe), level, held until grant released.
REQ-007 DMRW  in  1  D-cache direction; 1 = burst read (refill), 0 = burst write (write-buffer flush).
REQ-008 DMAddress  in  ADDR_W  D-cache halfword start address.
REQ-009 DGrant  out  1  bus granted to D-cache.
REQ-010 DSDR_TxD  out  1  D-cache write-beat window; cache drives the next halfword onto MData.
REQ-011 DSDR_RxD  out  1  D-cache read-beat window; MData holds a valid refill halfword.
REQ-012 IStrobe  in  1  I-cache request; always a burst read.
REQ-013 IMAddress  in  ADDR_W  I-cache halfword start address.
REQ-014 IGrant  out  1  bus granted to I-cache.
REQ-015 ISDR_RxD  out  1  I-cache read-beat window.
REQ-016 SdrReq  out  1  command request to SDRAM controller.
REQ-017 SdrWrite  out  1  command direction, 1 = write.
REQ-018 SdrAddr  out  ADDR_W  burst start address, aligned to BURST_LEN.
REQ-019 SdrAck  in  1  controller accepted the command (one-cycle pulse).
REQ-020 SdrRdValid  in  1  one read halfword valid on MData this cycle.
REQ-021 SdrWrNext  in  1  controller samples one write halfword this cycle.
REQ-022 Busy  out  1  high in any state other than IDLE.

Function
REQ-023 FSM states: IDLE, CMD, XFER, RELEASE; registered state, one-hot or binary.
REQ-024 IDLE: if any strobe high, select owner, latch address and direction, go to CMD next edge; grant rises that edge (1-cycle latency from strobe sample).
REQ-025 Arbitration round-robin: with both strobes high, grant the requester that was not last owner; last_owner resets to I so D wins first contention.
REQ-026 Single requester is granted regardless of last_owner.
REQ-027 SdrAddr = latched address with low log2(BURST_LEN) bits cleared; stable from CMD through RELEASE.
REQ-028 SdrWrite = ~DMRW latched for D owner, 0 for I owner.
REQ-029 CMD: SdrReq held high until the cycle SdrAck is sampled high; next state XFER, SdrReq low in XFER.
REQ-030 XFER: beat counter (log2(BURST_LEN)+1 bits) cleared on entry, increments on each qualifying beat (SdrRdValid for reads, SdrWrNext for writes).
REQ-031 Beat windows combinational: DSDR_RxD = DGrant & XFER & read & SdrRdValid; DSDR_TxD = DGrant & XFER & write & SdrWrNext; ISDR_RxD = IGrant & XFER & SdrRdValid.
REQ-032 Qualifiers arriving outside XFER, or of the wrong direction, are ignored and never forwarded.
REQ-033 On the beat where counter = BURST_LEN-1, next state RELEASE; extra beats after that are ignored.
REQ-034 RELEASE: grant deasserted; update last_owner; return to IDLE only once the owner's strobe is low (prevents re-granting a stale request).
REQ-035 Owner strobe dropping during CMD/XFER is ignored; the burst always completes (SDRAM bursts are non-abortable).
REQ-036 Non-owner strobe is never granted before RELEASE->IDLE; at most one grant high at any time.
REQ-037 Counter and state saturate; no wrap-around past BURST_LEN beats.

Reset
REQ-038 Reset asserted at any time (including mid-burst) forces IDLE within the same cycle asynchronously.
REQ-039 Reset values: DGrant, IGrant, SdrReq, SdrWrite, Busy, all beat windows = 0; SdrAddr = 0; counter = 0; last_owner = I.
REQ-040 First grant is possible on the first rising edge after Reset deasserts.

Verification
REQ-041 D read: DStrobe=1, DMRW=1, DMAddress=0x00000106 -> DGrant next edge, SdrReq=1, SdrAddr=0x00000104, SdrWrite=0; after SdrAck and 4 SdrRdValid pulses exactly 4 DSDR_RxD pulses, then DGrant=0.
REQ-042 D write with gaps: DMRW=0, SdrWrNext pattern 1,0,1,1,0,1 -> DSDR_TxD mirrors it, RELEASE after 4th beat, ISDR_RxD stays 0.
REQ-043 Contention: DStrobe and IStrobe high from reset -> D served first, then I; repeat with both held -> alternation D,I,D,I; never both grants high.
REQ-044 Held strobe: owner keeps DStrobe high after its 4th beat -> grant stays low, state stays RELEASE until DStrobe=0, no second SdrReq.
REQ-045 Reset mid-XFER after 2 beats -> all outputs 0 immediately, Busy=0; a new IStrobe afterwards gets a full 4-beat burst with counter restarted.
REQ-046 Stray SdrRdValid in IDLE/CMD and a 5th beat in RELEASE -> no RxD/TxD pulse forwarded, state unaffected.
